udp_payload_buffer: RTL and testbench

Upstream payload stage for the UDP/IP transmitter. It accepts an application byte stream through a valid/ready handshake and packs the bytes big-endian into 32-bit words in an internal RAM, starting at word address 1. It then presents the completed frame to the transmitter: a 9-bit registered read port, plus `tx_data_length` and `tx_total_length`. The buffer holds one frame and stays locked until the transmitter signals completion.

---
 rtl/eth_pkg.sv | 17 +
 rtl/payload_ram.sv | 39 +++
 rtl/udp_payload_buffer.sv | 168 ++++++++++++++++
 tb/tb_udp_payload_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared header lengths and payload-buffer state encoding
package eth_pkg;

   localparam logic [15:0] UDP_HDR_LEN = 16'd8;
   localparam logic [15:0] IP_HDR_LEN  = 16'd20;
   localparam logic [15:0] MIN_PAYLOAD = 16'd18;

   // Last RAM word touched by padding: 18 bytes end in word 5 when data starts at word 1.
   localparam int PAD_LAST_WORD = 5;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FILL  = 3'd1;
   localparam logic [2:0] ST_PAD   = 3'd2;
   localparam logic [2:0] ST_READY = 3'd3;
   localparam logic [2:0] ST_DROP  = 3'd4;

endpackage

// File: rtl/payload_ram.sv
// rtl/payload_ram.sv - 2^ADDR_W x 32 simple dual-port RAM with registered read
module payload_ram #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   // Same-address write and read on one edge return the old word.
   always_comb begin
      rdata_d = mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rdata_q <= 32'd0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/udp_payload_buffer.sv
// rtl/udp_payload_buffer.sv - packs a byte stream into a one-frame word buffer for the UDP/IP transmitter
// Define UDP_PAD_EN to pad short frames to 18 payload bytes.
module udp_payload_buffer
   import eth_pkg::*;
#(
   parameter int ADDR_W    = 9,
   parameter int MAX_BYTES = 4 * ((1 << ADDR_W) - 1)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data,
   output logic [15:0]       tx_data_length,
   output logic [15:0]       tx_total_length,
   output logic              pkt_ready,
   input  logic              tx_done,
   output logic              err_oversize
);

   localparam logic [15:0] MAX_B = 16'(MAX_BYTES);

   logic [2:0]        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [31:0]       word_q, word_d;
   logic [15:0]       dlen_q, dlen_d;
   logic [15:0]       tlen_q, tlen_d;
   logic              err_q, err_d;

   logic              accept;
   logic [1:0]        lane;
   logic [15:0]       n_bytes;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       assembled;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;

   assign in_ready  = (state_q == ST_FILL) || (state_q == ST_DROP);
   assign accept    = in_valid && in_ready;
   assign lane      = cnt_q[1:0];
   assign n_bytes   = cnt_q + 16'd1;
   assign cur_addr  = wptr_q + ADDR_W'(1);
   // word_q keeps lower lanes at zero, so a last byte self-pads its word.
   assign assembled = ((lane == 2'd0) ? 32'd0 : word_q) | ({24'd0, in_data} << {~lane, 3'b000});

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      word_d  = word_q;
      dlen_d  = dlen_q;
      tlen_d  = tlen_q;
      err_d   = 1'b0;
      we      = 1'b0;
      waddr   = cur_addr;
      wdata   = assembled;
      case (state_q)
         ST_IDLE: state_d = ST_FILL;
         ST_FILL: begin
            if (accept) begin
               if (cnt_q == MAX_B) begin
                  if (in_last) begin
                     err_d  = 1'b1;
                     cnt_d  = 16'd0;
                     wptr_d = '0;
                     word_d = 32'd0;
                  end else begin
                     state_d = ST_DROP;
                  end
               end else begin
                  cnt_d  = n_bytes;
                  word_d = assembled;
                  if (lane == 2'd3 || in_last) begin
                     we     = 1'b1;
                     wptr_d = cur_addr;
                     word_d = 32'd0;
                  end
                  if (in_last) begin
                     dlen_d  = n_bytes + UDP_HDR_LEN;
                     tlen_d  = n_bytes + UDP_HDR_LEN + IP_HDR_LEN;
                     state_d = ST_READY;
`ifdef UDP_PAD_EN
                     if (n_bytes < MIN_PAYLOAD) begin
                        dlen_d = MIN_PAYLOAD + UDP_HDR_LEN;
                        tlen_d = MIN_PAYLOAD + UDP_HDR_LEN + IP_HDR_LEN;
                        if (cur_addr < ADDR_W'(PAD_LAST_WORD)) begin
                           state_d = ST_PAD;
                        end
                     end
`endif
                  end
               end
            end
         end
`ifdef UDP_PAD_EN
         ST_PAD: begin
            we     = 1'b1;
            wdata  = 32'd0;
            wptr_d = cur_addr;
            if (cur_addr == ADDR_W'(PAD_LAST_WORD)) begin
               state_d = ST_READY;
            end
         end
`endif
         ST_READY: begin
            if (tx_done) begin
               state_d = ST_FILL;
               cnt_d   = 16'd0;
               wptr_d  = '0;
               word_d  = 32'd0;
            end
         end
         ST_DROP: begin
            if (accept && in_last) begin
               err_d   = 1'b1;
               state_d = ST_FILL;
               cnt_d   = 16'd0;
               wptr_d  = '0;
               word_d  = 32'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         wptr_q  <= '0;
         word_q  <= 32'd0;
         dlen_q  <= 16'd0;
         tlen_q  <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         word_q  <= word_d;
         dlen_q  <= dlen_d;
         tlen_q  <= tlen_d;
         err_q   <= err_d;
      end
   end

   assign pkt_ready       = (state_q == ST_READY);
   assign err_oversize    = err_q;
   assign tx_data_length  = dlen_q;
   assign tx_total_length = tlen_q;

   payload_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (clk),
      .clr  (clr),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(rd_addr),
      .rdata(rd_data)
   );

endmodule

// File: tb/tb_udp_payload_buffer.sv
// tb/tb_udp_payload_buffer.sv - directed self-checking bench for udp_payload_buffer
module tb_udp_payload_buffer;

   logic        clk = 1'b0;
   logic        clr;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [8:0]  rd_addr;
   logic [31:0] rd_data;
   logic [15:0] tx_data_length;
   logic [15:0] tx_total_length;
   logic        pkt_ready;
   logic        tx_done;
   logic        err_oversize;

   int vectors = 0;
   int errors  = 0;
   int err_pulses = 0;

   udp_payload_buffer dut (
      .clk            (clk),
      .clr            (clr),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .tx_data_length (tx_data_length),
      .tx_total_length(tx_total_length),
      .pkt_ready      (pkt_ready),
      .tx_done        (tx_done),
      .err_oversize   (err_oversize)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_oversize) err_pulses <= err_pulses + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int guard = 0;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = l;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Call right after send_byte of the last byte; checks cycles to pkt_ready.
   task automatic wait_ready(input string tag, input int exp_lat);
      int cyc = 1;
      while (!pkt_ready && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk(tag, cyc, exp_lat);
   endtask

   task automatic read_word(input logic [8:0] a, output logic [31:0] d);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic release_buf();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      int          pulses0;

      clr      = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      in_last  = 1'b0;
      rd_addr  = 9'd0;
      tx_done  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
      chk("rst_err", {31'd0, err_oversize}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_dlen", {16'd0, tx_data_length}, 32'd0);
      chk("rst_tlen", {16'd0, tx_total_length}, 32'd0);
      clr = 1'b1;

      // Aligned frame 01..08
      for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
      wait_ready("aligned_latency", 1);
      chk("aligned_dlen", {16'd0, tx_data_length}, 32'd16);
      chk("aligned_tlen", {16'd0, tx_total_length}, 32'd36);
      read_word(9'd1, w); chk("aligned_w1", w, 32'h01020304);
      read_word(9'd2, w); chk("aligned_w2", w, 32'h05060708);
      chk("ready_in_ready", {31'd0, in_ready}, 32'd0);
      release_buf();
      chk("rel_pkt_ready", {31'd0, pkt_ready}, 32'd0);
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // Partial word AA..EE
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      send_byte(8'hDD, 1'b0);
      send_byte(8'hEE, 1'b1);
      wait_ready("partial_latency", 1);
      chk("partial_dlen", {16'd0, tx_data_length}, 32'd13);
      chk("partial_tlen", {16'd0, tx_total_length}, 32'd33);
      read_word(9'd1, w); chk("partial_w1", w, 32'hAABBCCDD);
      read_word(9'd2, w); chk("partial_w2", w, 32'hEE000000);

      // Backpressure while READY
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_last  = 1'b1;
      repeat (5) @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_pkt_ready", {31'd0, pkt_ready}, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      read_word(9'd1, w); chk("bp_w1", w, 32'hAABBCCDD);
      read_word(9'd2, w); chk("bp_w2", w, 32'hEE000000);
      chk("bp_dlen", {16'd0, tx_data_length}, 32'd13);
      release_buf();
      chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
      send_byte(8'h0A, 1'b0);
      send_byte(8'h0B, 1'b0);
      send_byte(8'h0C, 1'b0);
      send_byte(8'h0D, 1'b1);
      wait_ready("bp_new_latency", 1);
      read_word(9'd1, w); chk("bp_new_w1", w, 32'h0A0B0C0D);
      chk("bp_new_dlen", {16'd0, tx_data_length}, 32'd12);
      chk("bp_new_tlen", {16'd0, tx_total_length}, 32'd32);
      release_buf();

      // Short frame; tx_done mid-frame must be ignored
      send_byte(8'h11, 1'b0);
      @(negedge clk); tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0;
      chk("fill_tx_done_ignored", {31'd0, in_ready}, 32'd1);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
`ifdef UDP_PAD_EN
      wait_ready("short_latency", 5);
      chk("short_dlen", {16'd0, tx_data_length}, 32'd26);
      chk("short_tlen", {16'd0, tx_total_length}, 32'd46);
      for (int a = 2; a <= 5; a++) begin
         read_word(9'(a), w);
         chk("short_pad_word", w, 32'd0);
      end
`else
      wait_ready("short_latency", 1);
      chk("short_dlen", {16'd0, tx_data_length}, 32'd11);
      chk("short_tlen", {16'd0, tx_total_length}, 32'd31);
`endif
      read_word(9'd1, w); chk("short_w1", w, 32'h11223300);
      release_buf();

      // Oversize: 2045 bytes, then a separate last byte
      pulses0 = err_pulses;
      for (int i = 0; i < 2045; i++) send_byte(8'(i), 1'b0);
      chk("drop_no_err_yet", {31'd0, err_oversize}, 32'd0);
      send_byte(8'h5A, 1'b1);
      chk("drop_err_pulse", {31'd0, err_oversize}, 32'd1);
      @(posedge clk); #1;
      chk("drop_err_fall", {31'd0, err_oversize}, 32'd0);
      chk("drop_pkt_ready", {31'd0, pkt_ready}, 32'd0);
      chk("drop_pulse_count", err_pulses - pulses0, 32'd1);
      chk("drop_in_ready", {31'd0, in_ready}, 32'd1);

      // Byte MAX_BYTES+1 itself carries in_last
      for (int i = 0; i < 2044; i++) send_byte(8'(i), 1'b0);
      send_byte(8'hA5, 1'b1);
      chk("drop_imm_err", {31'd0, err_oversize}, 32'd1);
      chk("drop_imm_pkt_ready", {31'd0, pkt_ready}, 32'd0);
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      send_byte(8'hBE, 1'b0);
      send_byte(8'hEF, 1'b1);
      wait_ready("after_drop_latency", 1);
      chk("after_drop_dlen", {16'd0, tx_data_length}, 32'd12);
      chk("after_drop_tlen", {16'd0, tx_total_length}, 32'd32);
      read_word(9'd1, w); chk("after_drop_w1", w, 32'hDEADBEEF);
      release_buf();

      // Reset mid-frame
      for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i), 1'b0);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
      chk("mid_rst_err", {31'd0, err_oversize}, 32'd0);
      chk("mid_rst_rd_data", rd_data, 32'd0);
      chk("mid_rst_dlen", {16'd0, tx_data_length}, 32'd0);
      chk("mid_rst_tlen", {16'd0, tx_total_length}, 32'd0);
      @(negedge clk);
      clr = 1'b1;
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b1);
      wait_ready("post_rst_latency", 1);
      chk("post_rst_dlen", {16'd0, tx_data_length}, 32'd10);
      chk("post_rst_tlen", {16'd0, tx_total_length}, 32'd30);
      read_word(9'd1, w); chk("post_rst_w1", w, 32'h12340000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
